// File: rtl/fm_demod_sched.sv
// FM discriminator sequencer: one shared 13x13 multiplier, 32-tap ring-buffer moving sum,
// flush/overrun handling. Define FM_DEMOD_SCHED_CLAMP_EN to clamp negative sums to zero on demod_data.
module fm_demod_sched #(
   parameter int DEPTH_LOG2 = 5
) (
   input  logic        data_clk,
   input  logic        RSTn,
   input  logic        sample_valid,
   input  logic [11:0] msi_i,
   input  logic [11:0] msi_q,
   input  logic        flush,
   input  logic        clr_overrun,
   output logic [11:0] demod_data,
   output logic        demod_valid,
   output logic        primed,
   output logic        busy,
   output logic        overrun,
   output logic        probe1
);
   localparam int W    = 26 + DEPTH_LOG2;
   localparam int TAPS = 1 << DEPTH_LOG2;

   typedef enum logic [2:0] {IDLE, MUL_A, MUL_B, ACC, FLUSH} state_t;
   state_t state_reg, state_next;

   logic signed [12:0]    i_dly1, q_dly1, i_dly2, q_dly2;
   logic signed [12:0]    mul_x, mul_y;
   logic signed [25:0]    product, prod_a, diff;
   logic signed [25:0]    ring [TAPS];
   logic [DEPTH_LOG2-1:0] wr_ptr, flush_ptr;
   logic [DEPTH_LOG2:0]   fill;
   logic signed [W-1:0]   sum, sum_next, diff_ext, old_ext;
   logic [11:0]           data_next;
   logic                  flush_pending, accept, flush_go;

   assign accept   = (state_reg == IDLE) && sample_valid;
   assign flush_go = (state_reg == IDLE) && !sample_valid && (flush || flush_pending);
   assign busy     = (state_reg != IDLE);

   always_ff @(posedge data_clk or negedge RSTn) begin
      if (!RSTn) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (sample_valid)                 state_next = MUL_A;
            else if (flush || flush_pending)  state_next = FLUSH;
         end
         MUL_A:   state_next = MUL_B;
         MUL_B:   state_next = ACC;
         ACC:     state_next = IDLE;
         FLUSH:   if (&flush_ptr) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Single shared multiplier: operand pair chosen by which cross product is due.
   always_comb begin
      mul_x = i_dly1;
      mul_y = q_dly2;
      if (state_reg == MUL_A) begin
         mul_x = i_dly2;
         mul_y = q_dly1;
      end
   end
   assign product = 26'(mul_x) * 26'(mul_y);

   assign diff_ext = {{(W-26){diff[25]}}, diff};
   assign old_ext  = {{(W-26){ring[wr_ptr][25]}}, ring[wr_ptr]};
   assign sum_next = sum + diff_ext - old_ext;

`ifdef FM_DEMOD_SCHED_CLAMP_EN
   assign data_next = sum_next[W-1] ? 12'd0 : sum_next[W-6:W-17];
`else
   assign data_next = sum_next[W-6:W-17];
`endif

   always_ff @(posedge data_clk or negedge RSTn) begin
      if (!RSTn) begin
         i_dly1        <= '0;
         q_dly1        <= '0;
         i_dly2        <= '0;
         q_dly2        <= '0;
         prod_a        <= '0;
         diff          <= '0;
         sum           <= '0;
         wr_ptr        <= '0;
         flush_ptr     <= '0;
         fill          <= '0;
         flush_pending <= 1'b0;
         primed        <= 1'b0;
         overrun       <= 1'b0;
         demod_data    <= '0;
         demod_valid   <= 1'b0;
         probe1        <= 1'b0;
         for (int k = 0; k < TAPS; k++) ring[k] <= '0;
      end else begin
         demod_valid <= 1'b0;

         if (accept) begin
            i_dly2 <= i_dly1;
            q_dly2 <= q_dly1;
            i_dly1 <= {1'b0, msi_i};
            q_dly1 <= {1'b0, msi_q};
         end

         if (state_reg == MUL_A) prod_a <= product;
         if (state_reg == MUL_B) diff   <= prod_a - product;

         if (state_reg == ACC) begin
            sum          <= sum_next;
            ring[wr_ptr] <= diff;
            wr_ptr       <= wr_ptr + 1'b1;
            if (!fill[DEPTH_LOG2]) fill <= fill + 1'b1;
            // primed goes high on the update that brings fill to TAPS
            primed       <= primed | fill[DEPTH_LOG2] | (&fill[DEPTH_LOG2-1:0]);
            demod_data   <= data_next;
            demod_valid  <= 1'b1;
            probe1       <= sum_next[W-1];
         end

         if (flush_go) flush_ptr <= '0;

         if (state_reg == FLUSH) begin
            ring[flush_ptr] <= '0;
            flush_ptr       <= flush_ptr + 1'b1;
            if (&flush_ptr) begin
               sum    <= '0;
               wr_ptr <= '0;
               fill   <= '0;
               primed <= 1'b0;
               i_dly1 <= '0;
               q_dly1 <= '0;
               i_dly2 <= '0;
               q_dly2 <= '0;
            end
         end

         // A flush arriving mid-computation waits; one arriving during FLUSH is dropped.
         if (flush_go)                          flush_pending <= 1'b0;
         else if (flush && state_reg != FLUSH)  flush_pending <= 1'b1;

         if (sample_valid && state_reg != IDLE) overrun <= 1'b1;
         else if (clr_overrun)                  overrun <= 1'b0;
      end
   end
endmodule

// File: tb/tb_fm_demod_sched.sv
// Directed bench for fm_demod_sched: latency, moving sum, wrap, overrun, flush, async reset.
module tb_fm_demod_sched;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        sample_valid, flush, clr_overrun;
   logic [11:0] msi_i, msi_q;
   logic [11:0] demod_data;
   logic        demod_valid, primed, busy, overrun, probe1;
   int          tests = 0;
   int          fails = 0;
   int          busy_cycles, pulses;

`ifdef FM_DEMOD_SCHED_CLAMP_EN
   localparam logic [11:0] NEG_DATA = 12'd0;
`else
   localparam logic [11:0] NEG_DATA = 12'hFC2;
`endif

   always #5 clk = ~clk;

   fm_demod_sched dut (
      .data_clk    (clk),
      .RSTn        (rst_n),
      .sample_valid(sample_valid),
      .msi_i       (msi_i),
      .msi_q       (msi_q),
      .flush       (flush),
      .clr_overrun (clr_overrun),
      .demod_data  (demod_data),
      .demod_valid (demod_valid),
      .primed      (primed),
      .busy        (busy),
      .overrun     (overrun),
      .probe1      (probe1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Drive one sample at edge N; demod_valid is expected after edge N+4.
   task automatic send(input logic [11:0] i, input logic [11:0] q,
                       input logic [11:0] exp_data, input logic exp_probe, input string tag);
      int lat;
      @(posedge clk); #1;
      sample_valid = 1'b1;
      msi_i = i;
      msi_q = q;
      @(posedge clk); #1;
      sample_valid = 1'b0;
      check({tag, "_busy_hi"}, 32'(busy), 1);
      lat = 0;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk); #1;
         if (demod_valid) begin
            lat = k + 1;
            break;
         end
      end
      $display("[TB] %s i=%0d q=%0d -> data=0x%03h probe1=%0b primed=%0b edges=%0d",
               tag, i, q, demod_data, probe1, primed, lat);
      check({tag, "_latency"}, lat, 4);
      check({tag, "_busy_lo"}, 32'(busy), 0);
      check({tag, "_data"}, 32'(demod_data), 32'(exp_data));
      check({tag, "_probe1"}, 32'(probe1), 32'(exp_probe));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n        = 1'b0;
      sample_valid = 1'b0;
      flush        = 1'b0;
      clr_overrun  = 1'b0;
      msi_i        = '0;
      msi_q        = '0;
      repeat (3) @(posedge clk);
      #2;
      check("rst_data",    32'(demod_data), 0);
      check("rst_valid",   32'(demod_valid), 0);
      check("rst_primed",  32'(primed), 0);
      check("rst_busy",    32'(busy), 0);
      check("rst_overrun", 32'(overrun), 0);
      check("rst_probe1",  32'(probe1), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Constant input: both cross products cancel, primed on the 32nd output.
      for (int k = 1; k <= 40; k++) begin
         send(12'd100, 12'd100, 12'd0, 1'b0, "const");
         check("const_primed", 32'(primed), 32'(k >= 32));
      end
      check("const_overrun", 32'(overrun), 0);

      // Positive rotation: diff +1e6 -> 61.
      do_reset();
      send(12'd1000, 12'd0, 12'd0, 1'b0, "pos_a");
      send(12'd0, 12'd1000, 12'd61, 1'b0, "pos_b");
      @(posedge clk); #1;
      check("valid_one_cycle", 32'(demod_valid), 0);

      // Negative rotation: diff -1e6 -> -62 (or clamped).
      do_reset();
      send(12'd0, 12'd1000, 12'd0, 1'b0, "neg_a");
      send(12'd1000, 12'd0, NEG_DATA, 1'b1, "neg_b");

      // Alternation: diffs 0,+1e6,-1e6,...; window sum 0 from sample 33 on.
      do_reset();
      for (int k = 1; k <= 40; k++) begin
         if (k % 2 == 1) send(12'd1000, 12'd0, 12'd0, 1'b0, "alt");
         else            send(12'd0, 12'd1000, (k <= 32) ? 12'd61 : 12'd0, 1'b0, "alt");
         check("alt_primed", 32'(primed), 32'(k >= 32));
      end

      // Overrun: second strobe two clocks after acceptance is dropped.
      @(posedge clk); #1;
      sample_valid = 1'b1; msi_i = 12'd1000; msi_q = 12'd0;
      @(posedge clk); #1;
      sample_valid = 1'b0;
      @(posedge clk); #1;
      sample_valid = 1'b1;
      @(posedge clk); #1;
      sample_valid = 1'b0;
      @(posedge clk); #1;
      check("ovr_valid", 32'(demod_valid), 1);
      check("ovr_data", 32'(demod_data), 0);
      pulses = 0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         if (demod_valid) pulses++;
      end
      $display("[TB] overrun drop: extra pulses=%0d overrun=%0b", pulses, overrun);
      check("ovr_no_extra", pulses, 0);
      check("ovr_set", 32'(overrun), 1);

      // Set and clear in the same cycle: set wins.
      @(posedge clk); #1;
      sample_valid = 1'b1; msi_i = 12'd0; msi_q = 12'd1000;
      @(posedge clk); #1;
      clr_overrun = 1'b1;
      @(posedge clk); #1;
      sample_valid = 1'b0;
      clr_overrun  = 1'b0;
      check("ovr_set_wins", 32'(overrun), 1);
      repeat (4) @(posedge clk);
      #1;
      clr_overrun = 1'b1;
      @(posedge clk); #1;
      clr_overrun = 1'b0;
      $display("[TB] clr_overrun alone: overrun=%0b", overrun);
      check("ovr_cleared", 32'(overrun), 0);

      // Flush during MUL_B of the 32nd sample.
      do_reset();
      for (int k = 1; k <= 31; k++) send(12'd1000, 12'd0, 12'd0, 1'b0, "pre_flush");
      check("pre_flush_primed", 32'(primed), 0);
      @(posedge clk); #1;
      sample_valid = 1'b1; msi_i = 12'd0; msi_q = 12'd1000;
      @(posedge clk); #1;
      sample_valid = 1'b0;
      @(posedge clk); #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      @(posedge clk); #1;
      check("flush_out_valid", 32'(demod_valid), 1);
      check("flush_out_data", 32'(demod_data), 61);
      check("flush_out_primed", 32'(primed), 1);
      busy_cycles = 0;
      for (int c = 0; c < 60; c++) begin
         @(posedge clk); #1;
         sample_valid = 1'b0;
         if (busy) busy_cycles++;
         else if (busy_cycles > 0) break;
         if (busy_cycles == 10) begin
            sample_valid = 1'b1; msi_i = 12'd555; msi_q = 12'd555;
         end
      end
      $display("[TB] flush: busy cycles=%0d overrun=%0b primed=%0b", busy_cycles, overrun, primed);
      check("flush_busy_cycles", busy_cycles, 32);
      check("flush_overrun", 32'(overrun), 1);
      check("flush_primed", 32'(primed), 0);
      send(12'd1000, 12'd0, 12'd0, 1'b0, "post_flush_a");
      check("post_flush_primed", 32'(primed), 0);
      send(12'd0, 12'd1000, 12'd61, 1'b0, "post_flush_b");

      // Asynchronous reset mid-operation.
      @(posedge clk); #1;
      sample_valid = 1'b1; msi_i = 12'd1000; msi_q = 12'd0;
      @(posedge clk); #1;
      sample_valid = 1'b0;
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      check("arst_busy", 32'(busy), 0);
      check("arst_overrun", 32'(overrun), 0);
      check("arst_data", 32'(demod_data), 0);
      @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         if (demod_valid) pulses++;
      end
      $display("[TB] async reset mid-op: pulses after=%0d", pulses);
      check("arst_no_output", pulses, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/fm_demod_sched.md
# fm_demod_sched

Sequencing controller for the FM discriminator. It time-multiplexes one 13x13 signed multiplier across the two cross products of each I/Q sample pair. It also maintains the 32-tap moving sum using a ring buffer plus running accumulator, and handles warm-up, flush and overrun. It sits between the I/Q front end (sample strobe at or below data_clk/4) and the audio path, as a low-area discriminator with a handshake.

## Interface
Parameters:
- DEPTH_LOG2, 5, log2 of moving-sum taps (32); accumulator width W = 26 + DEPTH_LOG2

Ports:
- data_clk  in  1  system clock, all logic on rising edge
- RSTn  in  1  asynchronous active-low reset
- sample_valid  in  1  one-cycle strobe qualifying msi_i/msi_q
- msi_i  in  12  unsigned I sample
- msi_q  in  12  unsigned Q sample
- flush  in  1  pulse; request history clear
- clr_overrun  in  1  pulse; clears overrun
- demod_data  out  12  demodulated sample
- demod_valid  out  1  one-cycle strobe qualifying demod_data
- primed  out  1  high once 2^DEPTH_LOG2 differences accumulated since reset/flush
- busy  out  1  high whenever FSM not in IDLE
- overrun  out  1  sticky: sample_valid dropped
- probe1  out  1  sign bit of running sum

## Operation
- Samples are zero-extended to 13-bit signed. The delay pair i/q_dly1 (newest) and i/q_dly2 (previous) is shifted only on an accepted sample_valid.
- FSM states: IDLE, MUL_A, MUL_B, ACC, FLUSH.
  - IDLE:
    - sample_valid → shift delay regs → MUL_A.
    - Else, if a flush is pending → FLUSH (ptr=0).
  - MUL_A: prod_a <= i_dly2*q_dly1 (26-bit signed).
  - MUL_B: diff <= prod_a − i_dly1*q_dly2 (26-bit signed). Only one multiplier instance is allowed; operand muxes select by state.
  - ACC:
    - sum <= sum + diff − ring[wr_ptr] (W-bit signed, sign-extended operands).
    - ring[wr_ptr] <= diff; wr_ptr wraps modulo 2^DEPTH_LOG2.
    - fill count saturates at 2^DEPTH_LOG2.
    - → IDLE.
  - FLUSH:
    - ring[ptr] <= 0 per cycle for 2^DEPTH_LOG2 cycles, then → IDLE.
    - On the final cycle, also clear sum, wr_ptr, fill count, primed and the delay regs.
- flush while not IDLE or FLUSH: latched as pending, serviced on return to IDLE. flush during FLUSH: ignored.
- sample_valid while busy (including FLUSH): sample dropped, overrun <= 1.
  - Same-cycle overrun set and clr_overrun: set wins.
  - sample_valid and flush pending in IDLE: sample wins, flush stays pending.
- Output mapping, registered on the ACC→IDLE edge:
  - demod_data per Configuration.
  - probe1 <= sum_next[W−1].
- Only ACC pulses demod_valid, whether or not primed. Downstream gates on primed.

## Timing
- Reset values: demod_data 0, demod_valid 0, primed 0, busy 0, overrun 0, probe1 0; sum, ring, delay regs, pointers, fill count and flush-pending are all 0; state IDLE.
- Latency: sample_valid at edge N → demod_valid high for the cycle after edge N+4.
- busy high from edge N+1 through edge N+3.
- Minimum accepted sample spacing is 4 clocks; spacing 3 sets overrun.
- primed rises with the demod_valid of the 32nd accepted sample after reset/flush.
- Flush takes 2^DEPTH_LOG2 cycles in FLUSH; busy is high throughout.
- Reset mid-operation: immediate asynchronous return to reset values; no partial output.

## Configuration
- FM_DEMOD_SCHED_CLAMP_EN defined:
  - If sum is negative, demod_data = 0.
  - Otherwise demod_data = sum[W−6:W−17] (unsigned magnitude, [25:14] at default).
- Undefined: demod_data = sum[W−6:W−17] as two's complement, no clamping.
- probe1 behaves identically in both builds.

## Test plan
- Reset, then constant samples (100,100) every 4 clocks → demod_data 0 every output; primed rises on the 32nd demod_valid; overrun 0.
- Samples (1000,0) then (0,1000) → second output diff +1,000,000: demod_data 61, probe1 0, latency exactly 4 clocks.
- Samples (0,1000) then (1000,0) → probe1 1; demod_data 0 with CLAMP_EN, 12'hFC2 (−62) without.
- Steady (1000,0)/(0,1000) alternation for 40 samples → sum stable after 32 taps; ring wrap causes no glitch; demod_data constant once primed.
- sample_valid 2 clocks after an accepted sample → dropped, no extra demod_valid, overrun 1. Then clr_overrun together with a new overrun → overrun stays 1; clr_overrun alone → 0.
- flush asserted during MUL_B → current output completes, then 32 busy cycles of FLUSH. A sample during FLUSH sets overrun. Afterwards primed 0 and the next output reflects zeroed history.
